// File: rtl/clm_sbox_driver.sv
// Feeds a CLM-encoded AES state byte-by-byte through one clm_sbox and collects the results.
// Optional: define CLM_DRIVER_ZERO_RND_EN to skip the randomness handshake and drive zero masks.
module clm_sbox_driver #(
  parameter int d       = 4,
  parameter int N_BYTES = 16,
  localparam int W      = 8 + d,
  localparam int IW     = (N_BYTES > 1) ? $clog2(N_BYTES) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [N_BYTES*W-1:0] state_in,
  output logic                 busy,
  output logic                 done,
  output logic [N_BYTES*W-1:0] state_out,
  input  logic [7*d-1:0]       rnd_in,
  input  logic                 rnd_valid,
  output logic                 rnd_ready,
  output logic                 sbox_rst,
  output logic [W-1:0]         sbox_in,
  output logic [7*d-1:0]       sbox_r,
  output logic                 sbox_drdy_i,
  input  logic                 sbox_drdy_o,
  input  logic [W-1:0]         sbox_out
);

`ifdef CLM_DRIVER_ZERO_RND_EN
  localparam bit ZERO_RND = 1'b1;
`else
  localparam bit ZERO_RND = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, FETCH, ISSUE, WAIT, DONE} state_e;

  state_e               state_reg, state_next;
  logic [IW-1:0]        idx_reg;
  logic [N_BYTES*W-1:0] in_buf_reg;
  logic [N_BYTES*W-1:0] res_buf;
  logic [N_BYTES*W-1:0] state_out_reg;
  logic [W-1:0]         sbox_in_reg;
  logic [7*d-1:0]       sbox_r_reg;
  logic [W-1:0]         in_lane [N_BYTES];
  logic                 fetch_go, accept, fetch_fire, capture, last_lane;

  assign fetch_go   = ZERO_RND | rnd_valid;
  assign accept     = (state_reg == IDLE)  && start;
  assign fetch_fire = (state_reg == FETCH) && fetch_go;
  assign capture    = (state_reg == WAIT)  && sbox_drdy_o;
  assign last_lane  = (idx_reg == IW'(N_BYTES - 1));

  assign sbox_rst   = ~rst;
  assign sbox_in    = sbox_in_reg;
  assign sbox_r     = sbox_r_reg;
  // Result is visible during the DONE cycle itself, then held from the register.
  assign state_out  = (state_reg == DONE) ? res_buf : state_out_reg;

  always_comb begin
    state_next  = state_reg;
    busy        = 1'b0;
    done        = 1'b0;
    rnd_ready   = 1'b0;
    sbox_drdy_i = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) state_next = FETCH;
      end
      FETCH: begin
        busy      = 1'b1;
        rnd_ready = !ZERO_RND;
        if (fetch_go) state_next = ISSUE;
      end
      ISSUE: begin
        busy        = 1'b1;
        sbox_drdy_i = 1'b1;
        state_next  = WAIT;
      end
      WAIT: begin
        busy = 1'b1;
        if (sbox_drdy_o) state_next = last_lane ? DONE : FETCH;
      end
      DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  for (genvar gi = 0; gi < N_BYTES; gi++) begin : g_lane
    logic [W-1:0] res_lane_reg;

    assign in_lane[gi]          = in_buf_reg[gi*W +: W];
    assign res_buf[gi*W +: W]   = res_lane_reg;

    always_ff @(posedge clk) begin
      if (!rst) begin
        res_lane_reg <= '0;
      end else if (capture && (idx_reg == IW'(gi))) begin
        res_lane_reg <= sbox_out;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg     <= IDLE;
      idx_reg       <= '0;
      in_buf_reg    <= '0;
      state_out_reg <= '0;
      sbox_in_reg   <= '0;
      sbox_r_reg    <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        in_buf_reg <= state_in;
        idx_reg    <= '0;
      end
      // S-Box operands only move here, so they stay frozen through ISSUE and WAIT.
      if (fetch_fire) begin
        sbox_in_reg <= in_lane[idx_reg];
        sbox_r_reg  <= ZERO_RND ? '0 : rnd_in;
      end
      if (capture && !last_lane) idx_reg <= idx_reg + 1'b1;
      if (state_reg == DONE) state_out_reg <= res_buf;
    end
  end

endmodule

// File: tb/tb_clm_sbox_driver.sv
// Self-checking bench for clm_sbox_driver with a behavioural 6-cycle S-Box model.
// Honours CLM_DRIVER_ZERO_RND_EN to match the zero-randomness build.
module tb_clm_sbox_driver;
  localparam int D  = 4;
  localparam int NB = 16;
  localparam int W  = 8 + D;
  localparam int RW = 7 * D;
  localparam int NW = NB * W;
`ifdef CLM_DRIVER_ZERO_RND_EN
  localparam bit ZR = 1'b1;
`else
  localparam bit ZR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [NW-1:0] state_in = '0;
  logic          busy, done;
  logic [NW-1:0] state_out;
  logic [RW-1:0] rnd_in = '0;
  logic          rnd_valid = 1'b0;
  logic          rnd_ready, sbox_rst;
  logic [W-1:0]  sbox_in;
  logic [RW-1:0] sbox_r;
  logic          sbox_drdy_i, sbox_drdy_o;
  logic [W-1:0]  sbox_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  clm_sbox_driver #(.d(D), .N_BYTES(NB)) dut (
    .clk(clk), .rst(rst), .start(start), .state_in(state_in),
    .busy(busy), .done(done), .state_out(state_out),
    .rnd_in(rnd_in), .rnd_valid(rnd_valid), .rnd_ready(rnd_ready),
    .sbox_rst(sbox_rst), .sbox_in(sbox_in), .sbox_r(sbox_r),
    .sbox_drdy_i(sbox_drdy_i), .sbox_drdy_o(sbox_drdy_o), .sbox_out(sbox_out)
  );

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] aes_sbox(input logic [7:0] a);
    logic [7:0] inv = 8'h00;
    if (a != 8'h00)
      for (int i = 1; i < 256; i++)
        if (gmul(a, 8'(i)) == 8'h01) inv = 8'(i);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  // Toy CLM code: data byte plus a folded-nibble redundancy field.
  function automatic logic [W-1:0] enc(input logic [7:0] x);
    logic [7:0] f = x ^ (x >> 4);
    return {f[D-1:0], x};
  endfunction

  function automatic logic [NW-1:0] exp_state(input logic [NW-1:0] s);
    logic [NW-1:0] e = '0;
    for (int i = 0; i < NB; i++) e[i*W +: W] = enc(aes_sbox(s[i*W +: 8]));
    return e;
  endfunction

  function automatic logic [NW-1:0] rand_state();
    logic [NW-1:0] s = '0;
    for (int i = 0; i < NB; i++) s[i*W +: W] = enc(8'($urandom));
    return s;
  endfunction

  // S-Box model plus handshake monitors (cumulative counters, tests look at deltas).
  int            cnt_q = 0;
  logic [W-1:0]  lat_in = '0, lat_out = '0;
  logic [RW-1:0] lat_r = '0, acc_r = '0;
  logic          rv_q = 1'b1;
  int stab_bad = 0, r_bad = 0, issue_bad = 0, issue_cnt = 0, rr_cnt = 0;

  always @(posedge clk) begin
    rv_q <= rnd_valid;
    if (rnd_valid && rnd_ready) acc_r <= rnd_in;
    if (rnd_ready) rr_cnt <= rr_cnt + 1;
    if (sbox_rst) begin
      cnt_q <= 0;
    end else if (sbox_drdy_i) begin
      cnt_q     <= 1;
      lat_in    <= sbox_in;
      lat_r     <= sbox_r;
      lat_out   <= enc(aes_sbox(sbox_in[7:0]));
      issue_cnt <= issue_cnt + 1;
      if (sbox_r !== (ZR ? RW'(0) : acc_r)) r_bad <= r_bad + 1;
      if (!ZR && !rv_q) issue_bad <= issue_bad + 1;
    end else if (cnt_q != 0) begin
      if (sbox_in !== lat_in || sbox_r !== lat_r) stab_bad <= stab_bad + 1;
      cnt_q <= (cnt_q == 6) ? 0 : cnt_q + 1;
    end
  end
  assign sbox_drdy_o = (cnt_q == 6);
  assign sbox_out    = (cnt_q == 6) ? lat_out : '0;

  // One operation; cycle n is counted from the start-sampling edge (n=0).
  task automatic run_op(input logic [NW-1:0] sin, input bit rand_r,
                        input int stall_at, input int stall_len,
                        input int pulse_a, input int pulse_b, input int rst_at,
                        input int next_at, input logic [NW-1:0] next_sin, input int limit,
                        output int done_cyc, output int done_cnt, output logic [NW-1:0] res,
                        output logic busy_first, output logic busy_after, output logic busy_after2);
    done_cyc = -1; done_cnt = 0; res = '0;
    busy_first = 1'b0; busy_after = 1'b1; busy_after2 = 1'b1;
    @(negedge clk);
    state_in = sin; start = 1'b1; rnd_valid = 1'b1;
    rnd_in = rand_r ? RW'($urandom) : '0;
    for (int n = 1; n <= limit; n++) begin
      @(negedge clk);
      if (n == 1) busy_first = busy;
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) begin done_cyc = n; res = state_out; end
      end
      if (done_cyc >= 0 && n == done_cyc + 1) busy_after  = busy;
      if (done_cyc >= 0 && n == done_cyc + 2) busy_after2 = busy;
      start = (n == pulse_a || n == pulse_b || n == next_at);
      if (n == next_at) state_in = next_sin;
      rst = (rst_at > 0 && n >= rst_at && n < rst_at + 2) ? 1'b0 : 1'b1;
      rnd_valid = (n >= stall_at && n < stall_at + stall_len) ? 1'b0 : 1'b1;
      rnd_in = rand_r ? RW'($urandom) : '0;
    end
    start = 1'b0; rst = 1'b1; rnd_valid = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (rnd_ready !== 1'b0) begin errors++; $display("FAIL reset_rnd_ready got %b want 0", rnd_ready); end
    checks++; if (sbox_drdy_i !== 1'b0) begin errors++; $display("FAIL reset_drdy_i got %b want 0", sbox_drdy_i); end
    checks++; if (sbox_in !== '0) begin errors++; $display("FAIL reset_sbox_in got %h want 0", sbox_in); end
    checks++; if (sbox_r !== '0) begin errors++; $display("FAIL reset_sbox_r got %h want 0", sbox_r); end
    checks++; if (state_out !== '0) begin errors++; $display("FAIL reset_state_out got %h want 0", state_out); end
    checks++; if (sbox_rst !== 1'b1) begin errors++; $display("FAIL reset_sbox_rst got %b want 1", sbox_rst); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (sbox_rst !== 1'b0) begin errors++; $display("FAIL release_sbox_rst got %b want 0", sbox_rst); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %b want 0", busy); end
    $display("reset: outputs checked during and after reset");
  endtask

  task automatic test_basic();
    logic [NW-1:0] sin, res, e;
    logic bf, ba, ba2;
    int dc, dn, i0, s0, r0;
    for (int i = 0; i < NB; i++) sin[i*W +: W] = enc(8'(i));
    e = exp_state(sin);
    i0 = issue_cnt; s0 = stab_bad; r0 = r_bad;
    run_op(sin, 1'b0, -1, 0, -1, -1, -1, -1, '0, 140, dc, dn, res, bf, ba, ba2);
    checks++; if (dc != 8*NB + 1) begin errors++; $display("FAIL basic_done_cycle got %0d want %0d", dc, 8*NB + 1); end
    checks++; if (dn != 1) begin errors++; $display("FAIL basic_done_count got %0d want 1", dn); end
    checks++; if (res !== e) begin errors++; $display("FAIL basic_result got %h want %h", res, e); end
    checks++; if (res[7:0] !== 8'h63) begin errors++; $display("FAIL basic_lane0 got %h want 63", res[7:0]); end
    checks++; if (res[W +: 8] !== 8'h7C) begin errors++; $display("FAIL basic_lane1 got %h want 7c", res[W +: 8]); end
    checks++; if (res[15*W +: 8] !== 8'h76) begin errors++; $display("FAIL basic_lane15 got %h want 76", res[15*W +: 8]); end
    checks++; if (bf !== 1'b1) begin errors++; $display("FAIL basic_busy_c1 got %b want 1", bf); end
    checks++; if (ba !== 1'b0) begin errors++; $display("FAIL basic_busy_after got %b want 0", ba); end
    checks++; if (issue_cnt - i0 != NB) begin errors++; $display("FAIL basic_issues got %0d want %0d", issue_cnt - i0, NB); end
    checks++; if (stab_bad != s0) begin errors++; $display("FAIL basic_stability got %0d want %0d", stab_bad, s0); end
    checks++; if (r_bad != r0) begin errors++; $display("FAIL basic_sbox_r got %0d want %0d", r_bad, r0); end
    $display("basic: done at cycle %0d, result %h", dc, res);
  endtask

  task automatic test_random_rnd();
    logic [NW-1:0] sin, res;
    logic bf, ba, ba2;
    int dc, dn, s0, r0, b0, q0;
    for (int t = 0; t < 2; t++) begin
      sin = rand_state();
      s0 = stab_bad; r0 = r_bad; b0 = issue_bad; q0 = rr_cnt;
      run_op(sin, 1'b1, -1, 0, -1, -1, -1, -1, '0, 140, dc, dn, res, bf, ba, ba2);
      checks++; if (dc != 8*NB + 1) begin errors++; $display("FAIL rnd_done_cycle got %0d want %0d", dc, 8*NB + 1); end
      checks++; if (res !== exp_state(sin)) begin errors++; $display("FAIL rnd_result got %h want %h", res, exp_state(sin)); end
      checks++; if (stab_bad != s0) begin errors++; $display("FAIL rnd_stability got %0d want %0d", stab_bad, s0); end
      checks++; if (r_bad != r0) begin errors++; $display("FAIL rnd_sbox_r got %0d want %0d", r_bad, r0); end
      checks++; if (issue_bad != b0) begin errors++; $display("FAIL rnd_issue_no_valid got %0d want %0d", issue_bad, b0); end
      checks++;
      if (ZR ? (rr_cnt != q0) : (rr_cnt - q0 < NB)) begin
        errors++; $display("FAIL rnd_ready_cycles got %0d want %s", rr_cnt - q0, ZR ? "0" : ">=16");
      end
      $display("random_rnd[%0d]: done at cycle %0d, result %h", t, dc, res);
    end
  endtask

  task automatic test_stall();
    logic [NW-1:0] sin, res;
    logic bf, ba, ba2;
    int dc, dn, b0, want;
    sin = rand_state();
    b0 = issue_bad;
    want = 8*NB + 1 + (ZR ? 0 : 3);
    run_op(sin, 1'b1, 8*5 + 1, 3, -1, -1, -1, -1, '0, 145, dc, dn, res, bf, ba, ba2);
    checks++; if (dc != want) begin errors++; $display("FAIL stall_done_cycle got %0d want %0d", dc, want); end
    checks++; if (issue_bad != b0) begin errors++; $display("FAIL stall_issue_no_valid got %0d want %0d", issue_bad, b0); end
    checks++; if (res !== exp_state(sin)) begin errors++; $display("FAIL stall_result got %h want %h", res, exp_state(sin)); end
    $display("stall: done at cycle %0d (want %0d)", dc, want);
  endtask

  task automatic test_start_ignored();
    logic [NW-1:0] sin, sin2, res;
    logic bf, ba, ba2;
    int dc, dn, got;
    sin = rand_state(); sin2 = rand_state();
    run_op(sin, 1'b1, -1, 0, 10, 8*NB + 1, -1, 8*NB + 2, sin2, 8*NB + 3, dc, dn, res, bf, ba, ba2);
    checks++; if (dn != 1) begin errors++; $display("FAIL ignore_done_count got %0d want 1", dn); end
    checks++; if (dc != 8*NB + 1) begin errors++; $display("FAIL ignore_done_cycle got %0d want %0d", dc, 8*NB + 1); end
    checks++; if (res !== exp_state(sin)) begin errors++; $display("FAIL ignore_result got %h want %h", res, exp_state(sin)); end
    checks++; if (ba2 !== 1'b1) begin errors++; $display("FAIL ignore_restart_busy got %b want 1", ba2); end
    got = 0;
    for (int n = 0; n < 200 && got == 0; n++) begin
      @(negedge clk);
      if (done) begin got = 1; res = state_out; end
    end
    checks++; if (got != 1) begin errors++; $display("FAIL restart_done got %0d want 1", got); end
    checks++; if (res !== exp_state(sin2)) begin errors++; $display("FAIL restart_result got %h want %h", res, exp_state(sin2)); end
    @(negedge clk);
    $display("start_ignored: first done at cycle %0d, restart completed %0d", dc, got);
  endtask

  task automatic test_reset_mid();
    logic [NW-1:0] sin, res;
    logic bf, ba, ba2;
    int dc, dn;
    sin = rand_state();
    run_op(sin, 1'b1, -1, 0, -1, -1, 40, -1, '0, 150, dc, dn, res, bf, ba, ba2);
    checks++; if (dn != 0) begin errors++; $display("FAIL abort_done_count got %0d want 0", dn); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b want 0", busy); end
    checks++; if (state_out !== '0) begin errors++; $display("FAIL abort_state_out got %h want 0", state_out); end
    checks++; if (sbox_in !== '0 || sbox_r !== '0) begin
      errors++; $display("FAIL abort_sbox_operands got %h/%h want 0/0", sbox_in, sbox_r);
    end
    sin = rand_state();
    run_op(sin, 1'b1, -1, 0, -1, -1, -1, -1, '0, 140, dc, dn, res, bf, ba, ba2);
    checks++; if (dc != 8*NB + 1) begin errors++; $display("FAIL fresh_done_cycle got %0d want %0d", dc, 8*NB + 1); end
    checks++; if (res !== exp_state(sin)) begin errors++; $display("FAIL fresh_result got %h want %h", res, exp_state(sin)); end
    $display("reset_mid: aborted op gave %0d done, fresh op done at cycle %0d", 0, dc);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_random_rnd();
    test_stall();
    test_start_ignored();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
